// File: rtl/phase_sweep_scheduler.sv
// Sweeps one shared phase-difference calculator across N_NEUR neurons, writing each result back to the phase table.
// Optional PHASE_SCHED_AUTORUN_EN: a held start restarts the sweep straight from DONE.
module phase_sweep_scheduler #(
    parameter int N_NEUR = 15,
    parameter int PW     = 4,
    parameter int IW     = 4,
    parameter int WIN    = 16
) (
    input  logic          sclk,
    input  logic          re_n,
    input  logic          start,
    input  logic          hold,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_addr,
    input  logic [PW-1:0] cfg_data,
    input  logic [IW-1:0] rd_addr,
    output logic [PW-1:0] rd_data,
    input  logic [PW-1:0] calc_phase,
    output logic [IW-1:0] sel,
    output logic          calc_re,
    output logic [PW-1:0] phi_load,
    output logic          busy,
    output logic          sweep_done
);

    localparam int WW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam logic [IW:0]   N_IDX     = (IW+1)'(N_NEUR);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N_NEUR - 1);
    localparam logic [WW-1:0] WCNT_LAST = WW'(WIN - 1);

    typedef enum logic [2:0] {IDLE, LOAD, MEAS, CAPT, PAUSE, DONE} state_t;

    state_t        state_reg, state_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [WW-1:0] wcnt_reg, wcnt_next;

    logic [PW-1:0] tab_reg [N_NEUR];
    logic [PW-1:0] tab_rd  [2**IW];
    logic          cfg_hit;
    logic          capt_hit;

    assign cfg_hit  = (state_reg == IDLE) && cfg_we && ({1'b0, cfg_addr} < N_IDX);
    assign capt_hit = (state_reg == CAPT);

    // Capture and host writes never coincide: host writes only land in IDLE.
    genvar gi;
    generate
        for (gi = 0; gi < N_NEUR; gi++) begin : g_tab
            always_ff @(posedge sclk or negedge re_n) begin
                if (!re_n) begin
                    tab_reg[gi] <= '0;
                end else if (capt_hit && (idx_reg == IW'(gi))) begin
                    tab_reg[gi] <= calc_phase;
                end else if (cfg_hit && (cfg_addr == IW'(gi))) begin
                    tab_reg[gi] <= cfg_data;
                end
            end
        end
        // Full power-of-two view so out-of-range addresses read back as zero.
        for (gi = 0; gi < 2**IW; gi++) begin : g_rd
            if (gi < N_NEUR) begin : g_live
                assign tab_rd[gi] = tab_reg[gi];
            end else begin : g_pad
                assign tab_rd[gi] = '0;
            end
        end
    endgenerate

    assign rd_data  = tab_rd[rd_addr];
    assign phi_load = tab_rd[idx_reg];
    assign sel      = idx_reg;

    always_ff @(posedge sclk or negedge re_n) begin
        if (!re_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            wcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            wcnt_reg  <= wcnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        wcnt_next  = wcnt_reg;
        calc_re    = 1'b1;
        busy       = 1'b1;
        sweep_done = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    idx_next   = '0;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                wcnt_next  = '0;
                state_next = MEAS;
            end
            MEAS: begin
                calc_re   = 1'b0;
                wcnt_next = wcnt_reg + WW'(1);
                if (wcnt_reg == WCNT_LAST) begin
                    state_next = CAPT;
                end
            end
            CAPT: begin
                calc_re = 1'b0;
                if (idx_reg == LAST_IDX) begin
                    state_next = DONE;
                end else begin
                    idx_next   = idx_reg + IW'(1);
                    state_next = hold ? PAUSE : LOAD;
                end
            end
            PAUSE: begin
                if (!hold) begin
                    state_next = LOAD;
                end
            end
            DONE: begin
                sweep_done = 1'b1;
`ifdef PHASE_SCHED_AUTORUN_EN
                if (start) begin
                    idx_next   = '0;
                    state_next = LOAD;
                end else begin
                    state_next = IDLE;
                end
`else
                state_next = IDLE;
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_phase_sweep_scheduler.sv
// Directed bench for phase_sweep_scheduler with a slot-position model and a phi+1 calculator stand-in.
`timescale 1ns/1ps
module tb_phase_sweep_scheduler;

    localparam int N   = 15;
    localparam int WIN = 16;

    logic       sclk = 1'b0;
    logic       re_n = 1'b0;
    logic       start = 1'b0, hold = 1'b0, cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0, cfg_data = '0, rd_addr = '0;
    logic [3:0] rd_data, calc_phase, sel, phi_load;
    logic       calc_re, busy, sweep_done;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    phase_sweep_scheduler #(.N_NEUR(N), .PW(4), .IW(4), .WIN(WIN)) dut (
        .sclk(sclk), .re_n(re_n), .start(start), .hold(hold),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .calc_phase(calc_phase),
        .sel(sel), .calc_re(calc_re), .phi_load(phi_load),
        .busy(busy), .sweep_done(sweep_done)
    );

    always #5 sclk = ~sclk;

    // Calculator stand-in: latches phi while held in re, then reports phi+1.
    logic [3:0] calc_lat = '0;
    always @(posedge sclk) if (calc_re) calc_lat <= phi_load;
    assign calc_phase = calc_lat + 4'd1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    // Model: mode 0 idle, 1 in a neuron slot (pos 0 load, 1..WIN measure, WIN+1 capture), 2 paused, 3 done.
    int m_tab[16] = '{default: 0};
    int m_mode = 0, m_neur = 0, m_pos = 0;

    initial begin
        forever begin
            @(posedge sclk or negedge re_n);
            if (!re_n) begin
                m_mode = 0; m_neur = 0; m_pos = 0;
                foreach (m_tab[i]) m_tab[i] = 0;
            end else begin
                case (m_mode)
                    0: begin
                        if (cfg_we && cfg_addr < N) m_tab[cfg_addr] = cfg_data;
                        if (start) begin m_mode = 1; m_neur = 0; m_pos = 0; end
                    end
                    1: begin
                        if (m_pos == WIN + 1) begin
                            m_tab[m_neur] = calc_phase;
                            if (m_neur == N - 1) m_mode = 3;
                            else begin
                                m_neur++;
                                m_pos = 0;
                                if (hold) m_mode = 2;
                            end
                        end else m_pos++;
                    end
                    2: if (!hold) m_mode = 1;
                    default: m_mode = 0;
                endcase
            end
        end
    end

    always @(negedge sclk) begin
        if (cmp_en) begin
            check("busy", busy, int'(m_mode != 0));
            check("sweep_done", sweep_done, int'(m_mode == 3));
            check("calc_re", calc_re, int'(!(m_mode == 1 && m_pos >= 1)));
            check("rd_data", rd_data, (rd_addr < N) ? m_tab[rd_addr] : 0);
            if (m_mode == 1 || m_mode == 2) begin
                check("sel", sel, m_neur);
                check("phi_load", phi_load, m_tab[m_neur]);
            end
        end
    end

    task automatic cfg_write(input int a, input int d);
        cfg_we = 1'b1; cfg_addr = 4'(a); cfg_data = 4'(d);
        tick();
        cfg_we = 1'b0;
    endtask

    // Starts a sweep; len is the cycle (LOAD = 1) on which sweep_done is seen.
    task automatic run_sweep(input int hold_at, input int hold_len, input int poke_at,
                             input int rst_at, output int len);
        int n;
        bit stopped;
        stopped = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_we = 1'b0;
        n = 1;
        while (!sweep_done && n < 600 && !stopped) begin
            if (n == hold_at) hold = 1'b1;
            if (n == hold_at + hold_len) hold = 1'b0;
            if (hold_at > 0 && n == hold_at + 5) check("pause_calc_re", calc_re, 1);
            if (hold_at > 0 && n == hold_at + 6) begin
                check("resume_sel", sel, 4);
                check("resume_load_calc_re", calc_re, 1);
            end
            if (hold_at > 0 && n == hold_at + 7) check("resume_meas_calc_re", calc_re, 0);
            if (n == poke_at) begin cfg_we = 1'b1; cfg_addr = 4'd2; cfg_data = 4'd9; start = 1'b1; end
            if (n == poke_at + 1) begin cfg_we = 1'b0; start = 1'b0; end
            if (n == rst_at) begin
                check("pre_rst_sel", sel, 7);
                check("pre_rst_calc_re", calc_re, 0);
                re_n = 1'b0;
                #1;
                check("rst_busy", busy, 0);
                check("rst_sel", sel, 0);
                check("rst_calc_re", calc_re, 1);
                check("rst_phi_load", phi_load, 0);
                check("rst_done", sweep_done, 0);
                stopped = 1'b1;
            end else begin
                tick();
                n++;
            end
        end
        len = n;
        $display("sweep: cycles=%0d reset_cut=%0d", len, stopped);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int len;
        #12;
        check("reset_busy", busy, 0);
        check("reset_done", sweep_done, 0);
        check("reset_sel", sel, 0);
        check("reset_calc_re", calc_re, 1);
        check("reset_phi_load", phi_load, 0);
        check("reset_rd_data", rd_data, 0);
        cmp_en = 1'b1;
        @(posedge sclk); #1;
        re_n = 1'b1;

        for (int i = 1; i < N; i++) cfg_write(i, i);
        cfg_write(0, 5);
        cfg_write(15, 7);
        rd_addr = 4'd15; #1;
        check("rd_oob", rd_data, 0);
        rd_addr = 4'd0; #1;
        check("rd0_cfg", rd_data, 5);
        rd_addr = 4'd14; #1;
        check("rd14_cfg", rd_data, 14);

        // Write in the same cycle as start: neuron 0 must load the new value.
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 4'd0;
        run_sweep(0, 0, 0, 0, len);
        check("sweep1_len", len, 271);
        tick();
        check("busy_fall", busy, 0);
        for (int i = 0; i < N; i++) begin
            rd_addr = 4'(i); tick();
            check("sweep1_tab", rd_data, (i + 1) % 16);
        end

        run_sweep(72, 5, 10, 0, len);
        check("sweep2_len", len, 276);
        repeat (5) begin
            tick();
            check("no_resweep", busy, 0);
        end
        for (int i = 0; i < N; i++) begin
            rd_addr = 4'(i); tick();
            check("sweep2_tab", rd_data, (i + 2) % 16);
        end
        rd_addr = 4'd14; #1;
        check("wrap14", rd_data, 0);
        rd_addr = 4'd2; #1;
        check("busy_write_dropped", rd_data, 4);

        run_sweep(0, 0, 0, 130, len);
        tick(); tick();
        re_n = 1'b1;
        tick();
        check("post_rst_busy", busy, 0);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i); tick();
            check("post_rst_tab", rd_data, 0);
        end

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
